// File: rtl/float_copro_sched_if.sv
// Command/response/datapath bundle between two requesters, the scheduler and the float datapath.
// Latency: none, wires only.
// Backpressure: valid/ready on commands and responses; start/done pulses toward the datapath.
interface float_copro_sched_if #(
  parameter int N_EXPOSANT = 4,
  parameter int N_MANTISSE = 20
);
  localparam int FW = 1 + N_EXPOSANT + N_MANTISSE;

  logic          req0_valid;
  logic          req0_ready;
  logic [1:0]    req0_op;
  logic [FW-1:0] req0_a;
  logic [FW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [1:0]    req1_op;
  logic [FW-1:0] req1_a;
  logic [FW-1:0] req1_b;

  logic          rsp0_valid;
  logic          rsp0_ready;
  logic [FW-1:0] rsp0_data;
  logic          rsp0_err;
  logic          rsp1_valid;
  logic          rsp1_ready;
  logic [FW-1:0] rsp1_data;
  logic          rsp1_err;

  logic          dp_start;
  logic [1:0]    dp_op;
  logic [FW-1:0] dp_a;
  logic [FW-1:0] dp_b;
  logic          dp_done;
  logic [FW-1:0] dp_result;

  logic          busy;

  // Scheduler view
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data, rsp1_err,
    input  rsp1_ready,
    output dp_start, dp_op, dp_a, dp_b,
    input  dp_done, dp_result,
    output busy
  );

  // Environment view: requesters plus datapath
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data, rsp1_err,
    output rsp1_ready,
    input  dp_start, dp_op, dp_a, dp_b,
    output dp_done, dp_result,
    input  busy
  );
endinterface

// File: rtl/float_copro_sched.sv
// Round-robin two-port scheduler issuing one float op at a time to the shared datapath.
// Latency: accept T, dp_start T+1, dp_done T+1+L, response T+2+L; reserved op responds at T+1.
// Backpressure: commands only accepted in IDLE; response held until the owner's ready.
module float_copro_sched #(
  parameter int N_EXPOSANT     = 4,
  parameter int N_MANTISSE     = 20,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           reset,
  float_copro_sched_if.slave bus
);
  localparam int FW = 1 + N_EXPOSANT + N_MANTISSE;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] cnt;
  logic [1:0]    dp_op_q;
  logic [FW-1:0] dp_a_q, dp_b_q;
  logic [FW-1:0] rsp_data_q;
  logic          rsp_err_q;

  logic          grant;
  logic          ready0, ready1;
  logic          accept;
  logic [1:0]    sel_op;
  logic [FW-1:0] sel_a, sel_b;
  logic          rsp_take;
  logic          timed_out;

  // Arbitration, handshake decode and next-state selection
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
    // Gated with valid so an idle bus shows no ready at all
    ready0    = (state == ST_IDLE) && bus.req0_valid && !grant;
    ready1    = (state == ST_IDLE) && bus.req1_valid && grant;
    accept    = ready0 || ready1;
    sel_op    = grant ? bus.req1_op : bus.req0_op;
    sel_a     = grant ? bus.req1_a  : bus.req0_a;
    sel_b     = grant ? bus.req1_b  : bus.req0_b;
    rsp_take  = owner ? bus.rsp1_ready : bus.rsp0_ready;
    timed_out = (cnt == CNT_LAST);
    case (state)
      ST_IDLE:  if (accept) state_nxt = (sel_op == OP_RSVD) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.dp_done || timed_out) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_take) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Command capture, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      dp_op_q    <= 2'b00;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            if (sel_op == OP_RSVD) begin
              // Reserved ops never reach the datapath; dp_op keeps its last legal value
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end else begin
              dp_op_q <= sel_op;
              dp_a_q  <= sel_a;
              dp_b_q  <= sel_b;
            end
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (bus.dp_done) begin
            rsp_data_q <= bus.dp_result;
            rsp_err_q  <= 1'b0;
          end else if (timed_out) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = (state == ST_RESP) && !owner;
  assign bus.rsp1_valid = (state == ST_RESP) && owner;
  assign bus.rsp0_data  = rsp_data_q;
  assign bus.rsp1_data  = rsp_data_q;
  assign bus.rsp0_err   = rsp_err_q;
  assign bus.rsp1_err   = rsp_err_q;
  assign bus.dp_start   = (state == ST_ISSUE);
  assign bus.dp_op      = dp_op_q;
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.busy       = (state != ST_IDLE);
endmodule
